muldiv_iter: RTL
================

// Module: muldiv_iter
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit; takes M-extension ops out of the single-cycle ALU path.
//  Radix-2 iterative engine: shift-add multiply, restoring divide, one bit per cycle.
//  Sits in Execute beside the ALU; valid/ready on both sides so the pipeline stalls while busy.
//  Tag is passed through unchanged for writeback.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  TAG_W  5   width of passthrough tag (destination register index)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      kill in-flight op (sync, priority over all but reset)
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept (high only in IDLE)
//  in_op      in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in_a       in   XLEN   operand a (rs1 / dividend)
//  in_b       in   XLEN   operand b (rs2 / divisor)
//  in_tag     in   TAG_W  passthrough tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_result out  XLEN   result
//  out_tag    out  TAG_W  tag of the op that produced out_result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, out_result=0, out_tag=0, counter=0; in_ready=1 after release.
//  FSM: IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE), combinational from state.
//  Accept: edge with in_valid&&in_ready; op/a/b/tag captured; inputs may change afterwards.
//  IDLE: on accept, special case -> DONE directly, result loaded on that edge; else -> CALC, counter=XLEN-1.
//  Special cases (detected at accept, 1-cycle latency):
//   - DIV/DIVU b==0 -> all-ones; REM/REMU b==0 -> a.
//   - DIV a==MIN_INT(1 followed by XLEN-1 zeros), b==-1 -> a; REM same operands -> 0.
//  CALC: sign-handled ops convert operands to magnitude (signed: MULH both, MULHSU a only,
//   DIV/REM both); unsigned engine runs exactly XLEN iterations, counter decrements each cycle.
//   Multiply: 2*XLEN accumulator; divide: XLEN remainder + XLEN quotient, restoring.
//  Last CALC cycle (counter==0): sign fixup applied and out_result registered on that edge -> DONE.
//   MUL: low XLEN of product; MULH/MULHSU/MULHU: high XLEN; product negated (2*XLEN wide) if signs differ.
//   DIV: quotient negated if sign(a)!=sign(b); REM: remainder takes sign of a.
//  Latency: accept edge E; normal op out_valid high after edge E+XLEN; special case after edge E+1.
//  DONE: out_valid=1, out_result/out_tag stable until out_valid&&out_ready edge -> IDLE.
//   No accept in the handshake cycle (in_ready low); next accept earliest one cycle later.
//  flush=1 at any edge: -> IDLE, out_valid=0, counter cleared; a same-cycle in_valid is NOT accepted.
//  Reset mid-CALC/DONE: immediate return to reset values; partial result discarded.
//  out_result only changes on entry to DONE; X never propagates from unused accumulator bits.
// TESTING
//  MUL a=7,b=-3 -> out_result=0xFFFFFFEB, out_valid exactly 32 cycles after accept, tag echoed.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all after 1 cycle.
//  out_ready low 5 cycles in DONE -> result/tag held, in_ready low; then handshake, IDLE next edge.
//  flush at CALC counter=10, then rst_n pulse mid-op -> out_valid never rises; next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/muldiv_iter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_if
// Brief    : Request/response bundle between the Execute stage and the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_iter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Brief    : RV32M multiply/divide, radix-2 iterative (shift-add multiply,
//            restoring divide), one bit per cycle, tag passthrough.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    muldiv_iter_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;

    localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_out_tag;

    logic              w_accept;
    logic              w_is_div;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;

    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_mul_lo;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_div_hi;
    logic [XLEN-1:0]   w_div_lo;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_calc_res;

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_out_tag;

    // A flush in the same cycle as in_valid wins: the request is dropped.
    assign w_accept = bus.in_valid & (r_state == S_IDLE) & ~bus.flush;

    // Divide-by-zero and signed overflow bypass the engine entirely.
    assign w_is_div  = bus.in_op[2];
    assign w_b_zero  = (bus.in_b == '0);
    assign w_ovf     = w_is_div & ~bus.in_op[0] & (bus.in_a == c_MIN_INT) & (bus.in_b == '1);
    assign w_special = w_is_div & (w_b_zero | w_ovf);

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = bus.in_op[1] ? bus.in_a : '1;
        end else begin
            w_special_res = bus.in_op[1] ? '0 : bus.in_a;
        end
    end

    assign w_a_signed = (bus.in_op == c_OP_MULH) | (bus.in_op == c_OP_MULHSU) |
                        (w_is_div & ~bus.in_op[0]);
    assign w_b_signed = (bus.in_op == c_OP_MULH) | (w_is_div & ~bus.in_op[0]);
    assign w_a_neg    = w_a_signed & bus.in_a[XLEN-1];
    assign w_b_neg    = w_b_signed & bus.in_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -bus.in_a : bus.in_a;
    assign w_b_mag    = w_b_neg ? -bus.in_b : bus.in_b;

    // Multiply step: {hi,lo} holds partial product over the remaining multiplier bits.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi = w_sum[XLEN:1];
    assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};

    // Divide step: {hi,lo} is remainder:dividend, quotient bits shift into lo.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_opb};
    assign w_div_hi = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_div_lo = {r_lo[XLEN-2:0], ~w_trial[XLEN]};

    assign w_hi_nxt   = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_lo_nxt   = r_op[2] ? w_div_lo : w_mul_lo;
    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_calc_res = '0;
        if (!r_op[2]) begin
            w_calc_res = (r_op[1:0] == 2'b00) ? w_lo_nxt : w_prod_fix[2*XLEN-1:XLEN];
        end else if (!r_op[1]) begin
            w_calc_res = r_neg_q ? -w_lo_nxt : w_lo_nxt;
        end else begin
            w_calc_res = r_neg_r ? -w_hi_nxt : w_hi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept)      w_state_nxt = w_special ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == '0)   w_state_nxt = S_DONE;
                S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_out_tag <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.in_op;
                        r_tag <= bus.in_tag;
                        if (w_special) begin
                            r_result  <= w_special_res;
                            r_out_tag <= bus.in_tag;
                        end else begin
                            r_cnt   <= CW'(XLEN-1);
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_opb   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                    if (r_cnt == '0) begin
                        r_result  <= w_calc_res;
                        r_out_tag <= r_tag;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
